// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared encodings and sizing helpers for the hazard scoreboard.
// Instruction classes and stall causes are both 2-bit fields on the ID-side interface.
package hazard_scoreboard_unit_pkg;

    typedef enum logic [1:0] {
        ClassAlu  = 2'd0,
        ClassLoad = 2'd1,
        ClassMdu  = 2'd2,
        ClassAlt  = 2'd3
    } id_class_e;

    typedef enum logic [1:0] {
        CauseNone = 2'd0,
        CauseRaw  = 2'd1,
        CauseWaw  = 2'd2,
        CauseMdu  = 2'd3
    } stall_cause_e;

    // The largest value a timer holds is MDU_LAT+1, so values 0..MDU_LAT+1 must fit.
    function automatic int unsigned cnt_width(input int unsigned mdu_lat);
        return $clog2(mdu_lat + 2);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// ID-stage request and pipeline-control response bundle for the hazard scoreboard.
// The pipeline side drives the master modport; the scoreboard uses the slave modport.
interface hazard_scoreboard_unit_if #(
    parameter int unsigned RADDR_W     = 5,
    parameter int unsigned STALL_CNT_W = 16
);
    logic               id_valid;
    logic [RADDR_W-1:0] id_rs1;
    logic [RADDR_W-1:0] id_rs2;
    logic               id_rs1_use;
    logic               id_rs2_use;
    logic               id_is_branch;
    logic [RADDR_W-1:0] id_rd;
    logic               id_rd_wen;
    logic [1:0]         id_class;
    logic               flush_id;
    logic               freeze;

    logic                   pc_write;
    logic                   ifid_write;
    logic                   idex_bubble;
    logic [1:0]             stall_cause;
    logic [STALL_CNT_W-1:0] stall_cycles;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_use, id_rs2_use, id_is_branch,
        output id_rd, id_rd_wen, id_class, flush_id, freeze,
        input  pc_write, ifid_write, idex_bubble, stall_cause, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_use, id_rs2_use, id_is_branch,
        input  id_rd, id_rd_wen, id_class, flush_id, freeze,
        output pc_write, ifid_write, idex_bubble, stall_cause, stall_cycles
    );

endinterface

// File: rtl/hazard_scoreboard_unit_reg_timer.sv
// One loadable down-counter that saturates at zero; tracks cycles until a register's result
// can be forwarded. Holds while the pipe is frozen; a load overrides the decrement.
module hazard_scoreboard_unit_reg_timer #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             freeze,
    output logic [CNT_W-1:0] value
);

    logic [CNT_W-1:0] value_d, value_q;

    always_comb begin
        value_d = value_q;
        if (!freeze) begin
            if (load) begin
                value_d = load_value;
            end else if (value_q != '0) begin
                value_d = value_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Countdown-scoreboard hazard unit beside ID: RAW, WAW, MDU structural and freeze handling,
// pipeline enable/bubble generation and a saturating stall-cycle counter.
module hazard_scoreboard_unit
    import hazard_scoreboard_unit_pkg::*;
#(
    parameter int unsigned NREG        = 32,
    parameter int unsigned RADDR_W     = 5,
    parameter int unsigned LOAD_LAT    = 1,
    parameter int unsigned MDU_LAT     = 4,
    parameter int unsigned STALL_CNT_W = 16
) (
    input logic                   clk,
    input logic                   rst,
    hazard_scoreboard_unit_if.slave bus
);

    localparam int unsigned CNT_W = cnt_width(MDU_LAT);

    logic [NREG-1:0][CNT_W-1:0] cnt;
    logic [CNT_W-1:0]           issue_val;
    logic [CNT_W-1:0]           cnt_rs1, cnt_rs2, cnt_rd;
    logic                       raw, waw, mdu_conflict, hazard, issue, is_mdu;
    stall_cause_e               cause;

    logic [CNT_W-1:0]       mdu_busy_d, mdu_busy_q;
    logic [STALL_CNT_W-1:0] stall_d, stall_q;

    // x0 is never tracked, so its timer is a constant zero.
    assign cnt[0] = '0;

    for (genvar r = 1; r < NREG; r++) begin : g_timer
        hazard_scoreboard_unit_reg_timer #(
            .CNT_W(CNT_W)
        ) u_timer (
            .clk       (clk),
            .rst       (rst),
            .load      (issue && (bus.id_rd == RADDR_W'(r))),
            .load_value(issue_val),
            .freeze    (bus.freeze),
            .value     (cnt[r])
        );
    end

    assign is_mdu = (id_class_e'(bus.id_class) == ClassMdu);

    // Issue value is latency + 1 to cover the ID-to-EX gap.
    always_comb begin
        issue_val = CNT_W'(1);
        case (id_class_e'(bus.id_class))
            ClassLoad: issue_val = CNT_W'(LOAD_LAT + 1);
            ClassMdu:  issue_val = CNT_W'(MDU_LAT + 1);
            default:   issue_val = CNT_W'(1);
        endcase
    end

    assign cnt_rs1 = cnt[bus.id_rs1];
    assign cnt_rs2 = cnt[bus.id_rs2];
    assign cnt_rd  = cnt[bus.id_rd];

    // Branches consume sources in ID, one stage earlier than EX consumers.
    always_comb begin
        raw = 1'b0;
        if (bus.id_rs1_use && bus.id_rs1 != '0) begin
            raw = bus.id_is_branch ? (cnt_rs1 != '0) : (cnt_rs1 > CNT_W'(1));
        end
        if (bus.id_rs2_use && bus.id_rs2 != '0) begin
            raw = raw | (bus.id_is_branch ? (cnt_rs2 != '0) : (cnt_rs2 > CNT_W'(1)));
        end
    end

    assign waw          = bus.id_rd_wen && (bus.id_rd != '0) && (cnt_rd > issue_val);
    assign mdu_conflict = is_mdu && (mdu_busy_q != '0);
    assign hazard       = bus.id_valid && !bus.flush_id && (raw || waw || mdu_conflict);
    assign issue        = bus.id_valid && !bus.flush_id && !hazard && !bus.freeze &&
                          bus.id_rd_wen && (bus.id_rd != '0);

    always_comb begin
        cause = CauseNone;
        if (hazard) begin
            if (raw) begin
                cause = CauseRaw;
            end else if (waw) begin
                cause = CauseWaw;
            end else begin
                cause = CauseMdu;
            end
        end
    end

    always_comb begin
        mdu_busy_d = mdu_busy_q;
        stall_d    = stall_q;
        if (!bus.freeze) begin
            if (issue && is_mdu) begin
                mdu_busy_d = CNT_W'(MDU_LAT);
            end else if (mdu_busy_q != '0) begin
                mdu_busy_d = mdu_busy_q - 1'b1;
            end
            if (hazard && stall_q != '1) begin
                stall_d = stall_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdu_busy_q <= '0;
            stall_q    <= '0;
        end else begin
            mdu_busy_q <= mdu_busy_d;
            stall_q    <= stall_d;
        end
    end

    // Freeze dominates: hold PC and IF/ID but leave ID/EX untouched.
    assign bus.pc_write     = !bus.freeze && !hazard;
    assign bus.ifid_write   = !bus.freeze && !hazard;
    assign bus.idex_bubble  = !bus.freeze && hazard;
    assign bus.stall_cause  = cause;
    assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Scoreboard bench: stimulus pushes expected outputs from a timestamp-based reference model,
// a separate monitor pops and compares on every falling edge.
module tb_hazard_scoreboard_unit;

    localparam int unsigned SCW      = 7;
    localparam int unsigned LOAD_LAT = 1;
    localparam int unsigned MDU_LAT  = 4;
    localparam int          STALL_MAX = (1 << SCW) - 1;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic       br;
        logic [4:0] rd;
        logic       wen;
        logic [1:0] cls;
        logic       flush;
        logic       frz;
    } stim_t;

    typedef struct packed {
        logic           pc;
        logic           ifid;
        logic           bub;
        logic [1:0]     cause;
        logic [SCW-1:0] stalls;
    } exp_t;

    logic clk;
    logic rst;

    hazard_scoreboard_unit_if #(.RADDR_W(5), .STALL_CNT_W(SCW)) bus ();

    hazard_scoreboard_unit #(
        .NREG       (32),
        .RADDR_W    (5),
        .LOAD_LAT   (LOAD_LAT),
        .MDU_LAT    (MDU_LAT),
        .STALL_CNT_W(SCW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: time advances only on non-frozen edges; a register is ready at avail[r].
    longint avail [32];
    longint now_t;
    longint mdu_free;
    int     stalls;
    int     total;
    int     bad;
    exp_t   exp_q [$];

    function automatic longint rem(input logic [4:0] r);
        if (r == 5'd0 || avail[r] <= now_t) return 0;
        return avail[r] - now_t;
    endfunction

    function automatic stim_t mk(input logic [1:0] cls, input logic [4:0] rd, input logic wen,
                                 input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                                 input logic u2, input logic br);
        stim_t s;
        s = '0;
        s.valid = 1'b1;
        s.cls = cls;
        s.rd = rd;
        s.wen = wen;
        s.rs1 = rs1;
        s.u1 = u1;
        s.rs2 = rs2;
        s.u2 = u2;
        s.br = br;
        return s;
    endfunction

    task automatic cycle(input stim_t s, input bit do_rst, output bit hz);
        longint lat;
        bit raw, waw, mbusy;
        exp_t e;
        @(posedge clk);
        #1;
        rst              = do_rst;
        bus.id_valid     = s.valid;
        bus.id_rs1       = s.rs1;
        bus.id_rs2       = s.rs2;
        bus.id_rs1_use   = s.u1;
        bus.id_rs2_use   = s.u2;
        bus.id_is_branch = s.br;
        bus.id_rd        = s.rd;
        bus.id_rd_wen    = s.wen;
        bus.id_class     = s.cls;
        bus.flush_id     = s.flush;
        bus.freeze       = s.frz;
        if (do_rst) begin
            foreach (avail[i]) avail[i] = 0;
            now_t = 0;
            mdu_free = 0;
            stalls = 0;
        end
        lat = (s.cls == 2'd1) ? LOAD_LAT : (s.cls == 2'd2) ? MDU_LAT : 0;
        raw = 1'b0;
        if (s.u1 && s.rs1 != 0) raw = s.br ? (rem(s.rs1) > 0) : (rem(s.rs1) > 1);
        if (s.u2 && s.rs2 != 0) raw = raw || (s.br ? (rem(s.rs2) > 0) : (rem(s.rs2) > 1));
        waw   = s.wen && s.rd != 0 && rem(s.rd) > lat + 1;
        mbusy = (s.cls == 2'd2) && (mdu_free > now_t);
        hz    = s.valid && !s.flush && (raw || waw || mbusy);
        e.pc     = !s.frz && !hz;
        e.ifid   = !s.frz && !hz;
        e.bub    = !s.frz && hz;
        e.cause  = !hz ? 2'd0 : raw ? 2'd1 : waw ? 2'd2 : 2'd3;
        e.stalls = SCW'(stalls);
        exp_q.push_back(e);
        if (!do_rst && !s.frz) begin
            if (s.valid && !s.flush && !hz && s.wen && s.rd != 0) begin
                avail[s.rd] = now_t + lat + 2;
                if (s.cls == 2'd2) mdu_free = now_t + 1 + MDU_LAT;
            end
            if (hz && stalls < STALL_MAX) stalls++;
            now_t++;
        end
    endtask

    // Present an instruction until it leaves ID, as the real pipeline would hold it.
    task automatic run_instr(input stim_t s);
        bit hz;
        int n;
        n = 0;
        do begin
            cycle(s, 1'b0, hz);
            n++;
        end while (hz && n < 30);
        if (hz) begin
            total++;
            bad++;
            $display("FAIL issue_bound: instruction still stalled after %0d cycles, want issue", n);
        end
    endtask

    task automatic idle(input int n);
        bit hz;
        for (int i = 0; i < n; i++) cycle('0, 1'b0, hz);
    endtask

    initial begin : monitor
        exp_t e, got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = {bus.pc_write, bus.ifid_write, bus.idex_bubble, bus.stall_cause,
                       bus.stall_cycles};
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL outputs @%0t: got pc=%0b ifid=%0b bub=%0b cause=%0d stalls=%0d want pc=%0b ifid=%0b bub=%0b cause=%0d stalls=%0d",
                             $time, got.pc, got.ifid, got.bub, got.cause, got.stalls,
                             e.pc, e.ifid, e.bub, e.cause, e.stalls);
                end
            end
        end
    end

    initial begin : stimulus
        bit hz, held, do_rst;
        stim_t s, f;
        total = 0;
        bad = 0;
        rst = 1'b1;
        bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rs1_use = 0;
        bus.id_rs2_use = 0; bus.id_is_branch = 0; bus.id_rd = 0; bus.id_rd_wen = 0;
        bus.id_class = 0; bus.flush_id = 0; bus.freeze = 0;
        cycle('0, 1'b1, hz);
        cycle('0, 1'b1, hz);
        idle(2);

        // Load-use.
        run_instr(mk(2'd1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0));
        run_instr(mk(2'd0, 5'd6, 1, 5'd5, 1, 5'd1, 1, 0));
        idle(3);
        // ALU -> branch, LOAD -> branch.
        run_instr(mk(2'd0, 5'd7, 1, 5'd0, 0, 5'd0, 0, 0));
        run_instr(mk(2'd0, 5'd0, 0, 5'd7, 1, 5'd0, 0, 1));
        run_instr(mk(2'd1, 5'd7, 1, 5'd0, 0, 5'd0, 0, 0));
        run_instr(mk(2'd0, 5'd0, 0, 5'd7, 1, 5'd0, 0, 1));
        idle(3);
        // Back-to-back MDU then consumer of the first MDU.
        run_instr(mk(2'd2, 5'd8, 1, 5'd0, 0, 5'd0, 0, 0));
        run_instr(mk(2'd2, 5'd9, 1, 5'd0, 0, 5'd0, 0, 0));
        run_instr(mk(2'd0, 5'd11, 1, 5'd8, 1, 5'd0, 0, 0));
        idle(6);
        // WAW behind MDU; x0 never tracked.
        run_instr(mk(2'd2, 5'd10, 1, 5'd0, 0, 5'd0, 0, 0));
        run_instr(mk(2'd0, 5'd10, 1, 5'd0, 0, 5'd0, 0, 0));
        run_instr(mk(2'd1, 5'd0, 1, 5'd0, 0, 5'd0, 0, 0));
        run_instr(mk(2'd0, 5'd12, 1, 5'd0, 1, 5'd0, 1, 1));
        idle(6);
        // Freeze over a load-use pair.
        run_instr(mk(2'd1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0));
        f = mk(2'd0, 5'd6, 1, 5'd5, 1, 5'd0, 0, 0);
        f.frz = 1'b1;
        for (int i = 0; i < 3; i++) cycle(f, 1'b0, hz);
        f.frz = 1'b0;
        run_instr(f);
        idle(3);
        // Reset in the middle of an MDU structural stall.
        run_instr(mk(2'd2, 5'd8, 1, 5'd0, 0, 5'd0, 0, 0));
        s = mk(2'd2, 5'd9, 1, 5'd0, 0, 5'd0, 0, 0);
        cycle(s, 1'b0, hz);
        cycle(s, 1'b1, hz);
        run_instr(mk(2'd0, 5'd13, 1, 5'd8, 1, 5'd0, 0, 0));
        idle(2);

        // Random traffic; stalled instructions are held in ID until they issue.
        held = 1'b0;
        s = '0;
        for (int i = 0; i < 4000; i++) begin
            do_rst = ($urandom_range(0, 299) == 0);
            if (!held) begin
                s.valid = ($urandom_range(0, 9) != 0);
                s.rs1   = 5'($urandom_range(0, 7));
                s.rs2   = 5'($urandom_range(0, 7));
                s.u1    = 1'($urandom_range(0, 1));
                s.u2    = 1'($urandom_range(0, 1));
                s.br    = ($urandom_range(0, 4) == 0);
                s.rd    = 5'($urandom_range(0, 7));
                s.wen   = ($urandom_range(0, 4) != 0);
                s.cls   = 2'($urandom_range(0, 3));
            end
            s.flush = ($urandom_range(0, 11) == 0);
            s.frz   = ($urandom_range(0, 7) == 0);
            cycle(s, do_rst, hz);
            held = (hz || s.frz) && !s.flush && !do_rst;
        end

        idle(2);
        repeat (4) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
